// File: rtl/branch_target_buffer_pkg.sv
// rtl/branch_target_buffer_pkg.sv - shared types and address helpers for the branch target buffer
package branch_target_buffer_pkg;

  typedef logic [31:0] word_t;

  localparam int TAG_MAX_W = 30;
  typedef logic [TAG_MAX_W-1:0] tag_t;

  // Tags are held zero-extended so one entry type serves every ENTRIES value.
  typedef struct packed {
    logic  valid;
    tag_t  tag;
    word_t target;
  } btb_entry_t;

  function automatic tag_t pc_tag(word_t pc, int unsigned tag_w);
    return tag_t'(pc >> (32 - tag_w));
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// rtl/branch_target_buffer_if.sv - fetch lookup, execute update and statistics bundle
interface branch_target_buffer_if #(
  parameter int PERF_W = 16
);
  import branch_target_buffer_pkg::*;

  word_t              lookup_pc;
  logic               lookup_hit;
  logic               pred_taken;
  word_t              pred_npc;
  logic               upd_en;
  word_t              upd_pc;
  logic               upd_taken;
  word_t              upd_target;
  logic               upd_mispred;
  logic               flush;
  logic [PERF_W-1:0]  perf_hits;
  logic [PERF_W-1:0]  perf_mispred;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, flush,
    input  lookup_hit, pred_taken, pred_npc, perf_hits, perf_mispred
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_taken, upd_target, upd_mispred, flush,
    output lookup_hit, pred_taken, pred_npc, perf_hits, perf_mispred
  );

endinterface

// File: rtl/branch_target_buffer_sat_counter.sv
// rtl/branch_target_buffer_sat_counter.sv - saturating up/down counter with priority load
module sat_counter #(
  parameter int           W       = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end else if (dec && (q != '0)) begin
      q <= q - W'(1);
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// rtl/branch_target_buffer.sv - direct-mapped BTB with saturating direction counters and statistics
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PERF_W  = 16
) (
  input  logic CLK,
  input  logic nRST,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_RST   = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_W'(1 << (CNT_W - 1));

  btb_entry_t       btb_q [ENTRIES];
  logic [CNT_W-1:0] cnt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic             lk_hit;
  logic             lk_taken;
  logic             up_hit;
  logic             upd_live;

  assign lk_idx = bus.lookup_pc[IDX_W+1:2];
  assign up_idx = bus.upd_pc[IDX_W+1:2];

  assign lk_hit   = btb_q[lk_idx].valid && (btb_q[lk_idx].tag == pc_tag(bus.lookup_pc, TAG_W));
  assign up_hit   = btb_q[up_idx].valid && (btb_q[up_idx].tag == pc_tag(bus.upd_pc, TAG_W));
  assign lk_taken = lk_hit && (cnt_q[lk_idx] >= CNT_ALLOC);
  assign upd_live = bus.upd_en && !bus.flush;

  assign bus.lookup_hit = lk_hit;
  assign bus.pred_taken = lk_taken;
  assign bus.pred_npc   = lk_taken ? btb_q[lk_idx].target : bus.lookup_pc + 32'd4;

  // A taken update writes the same entry image whether it hit (tag/valid unchanged) or allocates.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '0;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
      end
    end else if (bus.upd_en && bus.upd_taken) begin
      btb_q[up_idx] <= '{valid: 1'b1, tag: pc_tag(bus.upd_pc, TAG_W), target: bus.upd_target};
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    logic sel;
    assign sel = upd_live && (up_idx == IDX_W'(g));

    sat_counter #(.W(CNT_W), .RST_VAL(CNT_RST)) u_dir (
      .clk      (CLK),
      .rst_n    (nRST),
      .inc      (sel && up_hit && bus.upd_taken),
      .dec      (sel && up_hit && !bus.upd_taken),
      .load     (sel && !up_hit && bus.upd_taken),
      .load_val (CNT_ALLOC),
      .q        (cnt_q[g])
    );
  end

  // Statistics still see updates that a flush drops.
  sat_counter #(.W(PERF_W), .RST_VAL({PERF_W{1'b0}})) u_perf_hits (
    .clk      (CLK),
    .rst_n    (nRST),
    .inc      (bus.upd_en && up_hit),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({PERF_W{1'b0}}),
    .q        (bus.perf_hits)
  );

  sat_counter #(.W(PERF_W), .RST_VAL({PERF_W{1'b0}})) u_perf_mispred (
    .clk      (CLK),
    .rst_n    (nRST),
    .inc      (bus.upd_en && bus.upd_mispred),
    .dec      (1'b0),
    .load     (1'b0),
    .load_val ({PERF_W{1'b0}}),
    .q        (bus.perf_mispred)
  );

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb/tb_branch_target_buffer.sv - self-checking bench for branch_target_buffer
module tb_branch_target_buffer;

  localparam int NE    = 16;
  localparam int CW    = 2;
  localparam int PW    = 4;
  localparam int PMAX  = 15;
  localparam int CMAX  = 3;
  localparam int CHALF = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  branch_target_buffer_if #(.PERF_W(PW)) bus ();

  branch_target_buffer #(.ENTRIES(NE), .CNT_W(CW), .PERF_W(PW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  bit          m_valid [NE];
  int unsigned m_tag   [NE];
  logic [31:0] m_tgt   [NE];
  int          m_cnt   [NE];
  int          m_hits  = 0;
  int          m_mis   = 0;

  function automatic int ix(input logic [31:0] pc);
    return int'((pc / 4) % NE);
  endfunction

  function automatic int unsigned tg(input logic [31:0] pc);
    return pc / (4 * NE);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[ix(pc)] && (m_tag[ix(pc)] == tg(pc));
  endfunction

  function automatic bit m_taken(input logic [31:0] pc);
    return m_hit(pc) && (m_cnt[ix(pc)] >= CHALF);
  endfunction

  function automatic logic [31:0] m_npc(input logic [31:0] pc);
    return m_taken(pc) ? m_tgt[ix(pc)] : pc + 32'd4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  int uk;
  assign uk = ix(bus.upd_pc);

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NE; i++) begin
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= CHALF - 1;
      end
      m_hits <= 0;
      m_mis  <= 0;
    end else if (bus.upd_en) begin
      if (m_hit(bus.upd_pc) && m_hits < PMAX) m_hits <= m_hits + 1;
      if (bus.upd_mispred && m_mis < PMAX) m_mis <= m_mis + 1;
      if (bus.flush) begin
        for (int i = 0; i < NE; i++) m_valid[i] <= 1'b0;
      end else if (m_hit(bus.upd_pc)) begin
        if (bus.upd_taken) begin
          m_cnt[uk] <= (m_cnt[uk] == CMAX) ? CMAX : m_cnt[uk] + 1;
          m_tgt[uk] <= bus.upd_target;
        end else begin
          m_cnt[uk] <= (m_cnt[uk] == 0) ? 0 : m_cnt[uk] - 1;
        end
      end else if (bus.upd_taken) begin
        m_valid[uk] <= 1'b1;
        m_tag[uk]   <= tg(bus.upd_pc);
        m_tgt[uk]   <= bus.upd_target;
        m_cnt[uk]   <= CHALF;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < NE; i++) m_valid[i] <= 1'b0;
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("cyc.lookup_hit",   32'(bus.lookup_hit),   32'(m_hit(bus.lookup_pc)));
      chk("cyc.pred_taken",   32'(bus.pred_taken),   32'(m_taken(bus.lookup_pc)));
      chk("cyc.pred_npc",     bus.pred_npc,          m_npc(bus.lookup_pc));
      chk("cyc.perf_hits",    32'(bus.perf_hits),    32'(m_hits));
      chk("cyc.perf_mispred", 32'(bus.perf_mispred), 32'(m_mis));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                        input bit mis, input bit fl);
    bus.upd_en      = 1'b1;
    bus.upd_pc      = pc;
    bus.upd_taken   = taken;
    bus.upd_target  = tgt;
    bus.upd_mispred = mis;
    bus.flush       = fl;
    step();
    bus.upd_en      = 1'b0;
    bus.upd_mispred = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic lk(input string nm, input logic [31:0] pc, input bit e_hit, input bit e_taken,
                    input logic [31:0] e_npc);
    bus.lookup_pc = pc;
    #1;
    chk({nm, ".hit"},   32'(bus.lookup_hit), 32'(e_hit));
    chk({nm, ".taken"}, 32'(bus.pred_taken), 32'(e_taken));
    chk({nm, ".npc"},   bus.pred_npc,        e_npc);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return $urandom & 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 2) * 64 + $urandom_range(0, 15) * 4);
  endfunction

  initial begin
    bus.lookup_pc   = 32'h0;
    bus.upd_en      = 1'b0;
    bus.upd_pc      = 32'h0;
    bus.upd_taken   = 1'b0;
    bus.upd_target  = 32'h0;
    bus.upd_mispred = 1'b0;
    bus.flush       = 1'b0;
    #1 nRST = 1'b0;
    cmp_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    lk("reset", 32'h40, 1'b0, 1'b0, 32'h44);
    chk("reset.perf_hits",    32'(bus.perf_hits),    32'h0);
    chk("reset.perf_mispred", 32'(bus.perf_mispred), 32'h0);

    do_upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    lk("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
    lk("alias_tag", 32'h440, 1'b0, 1'b0, 32'h444);

    repeat (2) do_upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    lk("hyst_nt2", 32'h40, 1'b1, 1'b0, 32'h44);
    repeat (3) do_upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    lk("hyst_t3", 32'h40, 1'b1, 1'b1, 32'h100);
    do_upd(32'h40, 1'b1, 32'h100, 1'b0, 1'b0);
    do_upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    lk("hyst_sat_nt1", 32'h40, 1'b1, 1'b1, 32'h100);
    do_upd(32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    lk("hyst_sat_nt2", 32'h40, 1'b1, 1'b0, 32'h44);

    bus.lookup_pc   = 32'h80;
    bus.upd_en      = 1'b1;
    bus.upd_pc      = 32'h80;
    bus.upd_taken   = 1'b1;
    bus.upd_target  = 32'h200;
    #1;
    chk("hazard.same_hit", 32'(bus.lookup_hit), 32'h0);
    step();
    bus.upd_en = 1'b0;
    chk("hazard.next_hit", 32'(bus.lookup_hit), 32'h1);
    chk("hazard.next_npc", bus.pred_npc, 32'h200);

    do_upd(32'hC0, 1'b1, 32'h300, 1'b0, 1'b0);
    do_upd(32'hC0, 1'b1, 32'h300, 1'b1, 1'b1);
    lk("flush_c0", 32'hC0, 1'b0, 1'b0, 32'hC4);
    lk("flush_40", 32'h40, 1'b0, 1'b0, 32'h44);
    lk("flush_80", 32'h80, 1'b0, 1'b0, 32'h84);
    chk("flush.perf_hits",    32'(bus.perf_hits),    32'd9);
    chk("flush.perf_mispred", 32'(bus.perf_mispred), 32'd1);

    lk("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    do_upd(32'h3C, 1'b1, 32'h500, 1'b0, 1'b0);
    lk("idx15", 32'h3C, 1'b1, 1'b1, 32'h500);
    lk("idx0", 32'h0, 1'b0, 1'b0, 32'h4);

    repeat (3) do_upd(32'h240, 1'b0, 32'h700, 1'b0, 1'b0);
    lk("nt_miss", 32'h240, 1'b0, 1'b0, 32'h244);
    chk("nt_miss.perf_hits", 32'(bus.perf_hits), 32'd9);

    repeat (20) do_upd(32'h600, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("perf_sat.mispred", 32'(bus.perf_mispred), 32'hF);
    chk("perf_sat.hits",    32'(bus.perf_hits),    32'd9);

    repeat (600) begin
      bus.lookup_pc   = rand_pc();
      bus.upd_en      = ($urandom_range(0, 3) != 0);
      bus.upd_pc      = rand_pc();
      bus.upd_taken   = $urandom_range(0, 1) == 1;
      bus.upd_target  = $urandom & 32'hFFFF_FFFC;
      bus.upd_mispred = $urandom_range(0, 1) == 1;
      bus.flush       = ($urandom_range(0, 39) == 0);
      step();
    end
    bus.upd_en      = 1'b0;
    bus.upd_mispred = 1'b0;
    bus.flush       = 1'b0;

    do_upd(32'h40, 1'b1, 32'h900, 1'b1, 1'b0);
    bus.lookup_pc = 32'h40;
    nRST = 1'b0;
    #1;
    chk("midreset.hit",          32'(bus.lookup_hit),   32'h0);
    chk("midreset.npc",          bus.pred_npc,          32'h44);
    chk("midreset.perf_hits",    32'(bus.perf_hits),    32'h0);
    chk("midreset.perf_mispred", 32'(bus.perf_mispred), 32'h0);
    step();
    nRST = 1'b1;

    repeat (100) begin
      bus.lookup_pc   = rand_pc();
      bus.upd_en      = ($urandom_range(0, 1) != 0);
      bus.upd_pc      = rand_pc();
      bus.upd_taken   = $urandom_range(0, 1) == 1;
      bus.upd_target  = $urandom & 32'hFFFF_FFFC;
      bus.upd_mispred = $urandom_range(0, 1) == 1;
      bus.flush       = 1'b0;
      step();
    end
    bus.upd_en = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
